// File: rtl/prog_sequence_generator_pkg.sv
// Shared types and reset-time table contents for the programmable sequence generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Index 0 sits in the low byte, so SEQ_DEFAULT[0] = 8'hAF.
  localparam logic [7:0][7:0] SEQ_DEFAULT = {
    8'h8D, 8'h0B, 8'hE2, 8'hFF, 8'h78, 8'hE2, 8'hBC, 8'hAF
  };

  function automatic logic [7:0] default_word(int unsigned i);
    logic [2:0] k;
    k = i[2:0];
    return SEQ_DEFAULT[k];
  endfunction

endpackage

// File: rtl/prog_sequence_generator_if.sv
// Control, configuration and stream-output bundle of the sequence generator.
interface prog_sequence_generator_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              start;
  logic              mode;
  logic [ADDR_W:0]   len;
  logic              enable;
  logic              ready;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              last;
  logic              done;
  logic              busy;

  modport master (
    output start, mode, len, enable, ready, cfg_we, cfg_addr, cfg_wdata,
    input  data, valid, last, done, busy
  );

  modport slave (
    input  start, mode, len, enable, ready, cfg_we, cfg_addr, cfg_wdata,
    output data, valid, last, done, busy
  );
endinterface

// File: rtl/prog_sequence_generator_seq_table.sv
// Pattern table: DEPTH x DATA_W registers, async reset to the default pattern,
// one write port and one combinational read port.
module seq_table
  import seq_gen_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we && (32'(waddr) < DEPTH)) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= DATA_W'(default_word(i));
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_sequence_generator.sv
// Programmable pattern source: replays the table in loop or one-shot mode over a
// valid/ready stream, with run-time programmable active length.
module prog_sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input logic                      clk,
  input logic                      reset,
  prog_sequence_generator_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LenMax = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              mode_q, mode_d;

  logic [ADDR_W:0]   len_norm;
  logic              at_last;
  logic              adv;
  logic [DATA_W-1:0] rdata;

  assign len_norm = ((bus.len == '0) || (bus.len > LenMax)) ? LenMax : bus.len;
  assign at_last  = ({1'b0, idx_q} == (len_q - 1'b1));
  assign adv      = (state_q == StRun) && bus.ready && bus.enable;

  // Writes are locked out while busy so presented data stays stable.
  seq_table #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (bus.cfg_we && (state_q == StIdle)),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_wdata),
    .raddr (idx_q),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= LenMax;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    mode_d  = mode_q;
    if (bus.start) begin
      state_d = StRun;
      idx_d   = '0;
      len_d   = len_norm;
      mode_d  = bus.mode;
    end else begin
      case (state_q)
        StRun: begin
          if (adv) begin
            if (at_last) begin
              idx_d = '0;
              if (mode_q) state_d = StDone;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
          idx_d   = '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.data  = rdata;
    bus.valid = (state_q == StRun);
    bus.last  = (state_q == StRun) && at_last;
    bus.done  = (state_q == StDone);
    bus.busy  = (state_q != StIdle);
  end

endmodule

// File: tb/tb_prog_sequence_generator.sv
// Scoreboard bench: stimulus updates a pattern-position model and queues expected
// outputs; a monitor pops and compares them every cycle.
module tb_prog_sequence_generator;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  prog_sequence_generator_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  prog_sequence_generator #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic       last;
    logic       done;
    logic       busy;
    logic       chk_data;
    logic [7:0] data;
  } ctl_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } xfer_t;

  ctl_t  cq[$];
  xfer_t xq[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Model: pattern table plus "which element is on offer" bookkeeping.
  logic [7:0] m_tbl [DEPTH];
  bit         m_run, m_one, m_donep;
  int         m_len, m_pos;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    logic [7:0] def [8];
    def = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
    for (int i = 0; i < int'(DEPTH); i++) m_tbl[i] = def[i % 8];
    m_run = 0; m_one = 0; m_donep = 0; m_len = DEPTH; m_pos = 0;
    cq.delete();
    xq.delete();
  endtask

  task automatic step(bit st, bit md, int ln, bit en, bit rd, bit we, int addr, logic [7:0] wd);
    ctl_t c;
    bit   fin;
    @(negedge clk);
    bus.start = st; bus.mode = md; bus.len = 4'(ln);
    bus.enable = en; bus.ready = rd;
    bus.cfg_we = we; bus.cfg_addr = 3'(addr); bus.cfg_wdata = wd;
    fin        = (m_pos == m_len - 1);
    c.valid    = m_run;
    c.last     = m_run && fin;
    c.done     = m_donep;
    c.busy     = m_run || m_donep;
    c.chk_data = !m_donep;
    c.data     = m_tbl[m_pos];
    cq.push_back(c);
    if (m_run && rd && en) xq.push_back({m_tbl[m_pos], fin});
    if (we && !(m_run || m_donep)) m_tbl[addr] = wd;
    if (st) begin
      m_run = 1; m_donep = 0; m_pos = 0; m_one = md;
      m_len = (ln == 0 || ln > int'(DEPTH)) ? DEPTH : ln;
    end else if (m_run && rd && en) begin
      if (fin) begin
        m_pos = 0;
        if (m_one) begin m_run = 0; m_donep = 1; end
      end else begin
        m_pos++;
      end
    end else if (m_donep) begin
      m_donep = 0;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 1, 0, 0, 8'h00);
  endtask

  // Monitor
  initial begin
    ctl_t  c;
    xfer_t x;
    forever begin
      @(negedge clk);
      #2;
      if (cq.size() > 0) begin
        c = cq.pop_front();
        check("valid", 32'(bus.valid), 32'(c.valid));
        check("last", 32'(bus.last), 32'(c.last));
        check("done", 32'(bus.done), 32'(c.done));
        check("busy", 32'(bus.busy), 32'(c.busy));
        if (c.chk_data) check("data", 32'(bus.data), 32'(c.data));
        if (c.valid && bus.ready && bus.enable) begin
          if (xq.size() == 0) begin
            check("xfer_queue", 32'(1), 32'(0));
          end else begin
            x = xq.pop_front();
            check("xfer_data", 32'(bus.data), 32'(x.data));
            check("xfer_last", 32'(bus.last), 32'(x.last));
          end
        end
      end
    end
  end

  initial begin
    bus.start = 0; bus.mode = 0; bus.len = '0; bus.enable = 0; bus.ready = 0;
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    model_reset();
    reset = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    check("rst_data", 32'(bus.data), 32'h AF);
    check("rst_valid", 32'(bus.valid), 32'(0));
    check("rst_last", 32'(bus.last), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    @(negedge clk);
    reset = 1'b0;

    // Loop, full length
    step(1, 0, 0, 1, 1, 0, 0, 8'h00);
    idle(19);
    // Backpressure on 0x78 (position 3)
    step(1, 0, 0, 1, 1, 0, 0, 8'h00);
    idle(3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 0, 8'h00);
    idle(4);
    // One-shot, len 3
    step(1, 1, 3, 1, 1, 0, 0, 8'h00);
    idle(6);
    // Config in IDLE, then ignored write during RUN
    step(0, 0, 0, 1, 1, 1, 2, 8'h55);
    step(1, 0, 0, 1, 1, 0, 0, 8'h00);
    idle(3);
    step(0, 0, 0, 1, 1, 1, 0, 8'h11);
    idle(8);
    // Loop len 1 keeps last high
    step(1, 0, 1, 1, 1, 0, 0, 8'h00);
    idle(4);
    // Async reset while 0xFF is on offer
    step(1, 0, 0, 1, 1, 0, 0, 8'h00);
    idle(4);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_valid", 32'(bus.valid), 32'(0));
    check("arst_busy", 32'(bus.busy), 32'(0));
    check("arst_data", 32'(bus.data), 32'h AF);
    check("arst_last", 32'(bus.last), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(1, 0, 0, 1, 1, 0, 0, 8'h00);
    idle(4);

    // Random episodes
    for (int e = 0; e < 40; e++) begin
      if ($urandom_range(0, 2) == 0) begin
        // let any run drain / settle to IDLE for config writes
        step(1, 1, 1, 1, 1, 0, 0, 8'h00);
        idle(3);
        for (int w = 0; w < 3; w++)
          step(0, 0, 0, 1, 1, 1, $urandom_range(0, DEPTH - 1), 8'($urandom));
      end
      step(1, 1'($urandom), $urandom_range(0, 15), 1, 1, 0, 0, 8'h00);
      for (int k = 0, n = $urandom_range(5, 30); k < n; k++)
        step(($urandom_range(0, 29) == 0), 1'($urandom), $urandom_range(0, 15),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 5) == 0), $urandom_range(0, DEPTH - 1), 8'($urandom));
    end
    idle(3);
    @(negedge clk);
    #3;
    check("ctl_drained", 32'(cq.size()), 32'(0));
    check("xfer_drained", 32'(xq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_sequence_generator.md
# prog_sequence_generator

Parametrised, programmable successor to the fixed 8-entry byte sequence generator. Replays a run-time-writable pattern table of DEPTH words of DATA_W bits, in loop or one-shot mode, with programmable active length. Output uses a valid/ready handshake so the block can feed a stream consumer directly. It sits in the stimulus/pattern path as a pattern source.

## Interface
- DATA_W, 8, width of each sequence word
- DEPTH, 8, table entries (≥2); ADDR_W = clog2(DEPTH), derived, not overridable

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state and reloads the default table
- start  in  1  pulse; (re)starts the sequence at index 0 and samples mode and len
- mode  in  1  0 = loop, 1 = one-shot
- len  in  ADDR_W+1  active length; 0 or >DEPTH means DEPTH
- enable  in  1  advance permission; low freezes index and data
- ready  in  1  downstream accept
- cfg_we  in  1  table write strobe
- cfg_addr  in  ADDR_W  table write address
- cfg_wdata  in  DATA_W  table write data
- data  out  DATA_W  table[idx]
- valid  out  1  data is a live sequence element
- last  out  1  valid and idx == len_q-1
- done  out  1  one-cycle pulse when a one-shot pass completes
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, RUN, DONE.
- Reset: state=IDLE, idx=0, len_q=DEPTH, mode_q=0, valid=0, last=0, done=0, busy=0.
- Reset table contents: entry i = SEQ_DEFAULT[i mod 8], where SEQ_DEFAULT = AF, BC, E2, 78, FF, E2, 0B, 8D. Each entry is zero-extended or truncated to DATA_W. Hence data=0xAF at reset for the default parameters.
- IDLE → RUN on start. In the same edge: idx←0, mode_q←mode, len_q←normalised len.
- Advance event (adv) = RUN & valid & ready & enable.
- On adv with idx < len_q-1: idx←idx+1.
- On adv with idx = len_q-1:
  - loop mode: idx←0 (wrap), stay in RUN.
  - one-shot mode: go to DONE.
- DONE lasts exactly one cycle: done=1, valid=0, idx←0, then → IDLE.
- start in RUN or DONE restarts: idx←0, mode_q and len_q re-sampled, state RUN. start has priority over a simultaneous adv.
- cfg_we is honoured only in IDLE. It is silently ignored when busy, so presented data is stable under backpressure.
- enable=0 or ready=0 in RUN: idx, data, valid and last all hold.
- Table reads are combinational from registered storage: data = table[idx] in every state.

## Timing
- valid=1 and data=table[0] the cycle after start is sampled. Latency from start to first element is 1 cycle.
- With ready=enable=1, one new element per cycle. A loop wrap costs zero bubbles.
- After the adv edge on the final element in one-shot mode: next cycle valid=0, done=1, busy=1. The cycle after that: done=0, busy=0.
- A cfg write in IDLE is visible on data (if idx matches) the cycle after the write edge.
- reset asserted mid-operation forces all outputs to their reset values immediately (asynchronous). There is no partial pass; the table returns to defaults.
- len_q=1: the single element repeats every cycle in loop mode, and last stays high.

## Structure
- Package seq_gen_pkg: state enum (IDLE/RUN/DONE) and the SEQ_DEFAULT 8×8-bit constant array.
- Sub-module seq_table: DEPTH×DATA_W register file with async reset to defaults, one write port and one combinational read port.
- Top module: FSM, index counter, length/mode capture and output decode.

## Test plan
- Reset held 10 cycles → data=0xAF, valid=0, last=0, done=0, busy=0.
- Loop mode: len=0, enable=ready=1, start pulse → data AF,BC,E2,78,FF,E2,0B,8D,AF,BC… one per cycle. last=1 only on 8D. done never asserts.
- Backpressure: drop ready, then separately enable, for 5 cycles while data=0x78 → data holds 0x78 with valid=1. On release, next element is 0xFF.
- One-shot: mode=1, len=3 → AF,BC,E2 (last on E2). Then valid=0 and a 1-cycle done pulse, busy falls one cycle later, data=0xAF.
- Config: in IDLE write addr2=0x55, then loop start → AF,BC,55,78…. A write to addr0 during RUN is ignored: 0xAF is seen on the wrap.
- Async reset asserted mid-cycle while data=0xFF in RUN → immediate valid=0, busy=0, data=0xAF. A previously written 0x55 is restored to 0xE2.
